cpu_run_monitor: RTL and testbench

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

---
 rtl/cpu_run_monitor.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor
//
// Watches a CPU's commit stream (pc_valid / pc / instr) for one program run and
// reports how the run ended. A run starts with the first committed PC. It stops
// when one of these happens:
//   - the CPU commits END_PC;
//   - the CPU commits the same PC STALL_LIMIT times in a row;
//   - TIMEOUT cycles pass in RUN.
// A normal stop spends one cycle in CHECK comparing check_val with expect_val.
// A timeout goes straight to DONE as a failure. DONE holds until reset.
// The most recent TRACE_DEPTH committed PCs are kept in a ring. They can be
// read combinationally, newest first.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   pc_valid       one-cycle strobe: pc/instr committed this cycle
//   pc, instr      committed PC and its instruction word
//   check_val      observed result, sampled during CHECK
//   expect_val     expected result, sampled during CHECK
//   trace_rd_idx   trace read index, 0 = most recent
//   done           run finished (terminal)
//   pass / fail    verdict; mutually exclusive, valid while done=1
//   timed_out      run ended by TIMEOUT
//   cycle_count    cycles spent in RUN (saturating)
//   instr_count    strobes accepted in IDLE->RUN and RUN (saturating)
//   trace_count    number of valid trace entries (saturates at TRACE_DEPTH)
//   trace_rd_pc    PC at trace_rd_idx; 0 if the entry is not valid
//   trace_rd_instr instruction at trace_rd_idx; 0 if the entry is not valid
//
// Build option
//   CPU_RUN_MONITOR_INSTR_TRACE_EN
//     Defined:   the ring stores {pc, instr} and trace_rd_instr is live.
//     Undefined: the ring stores pc only and trace_rd_instr is tied to 0.
// -----------------------------------------------------------------------------
module cpu_run_monitor #(
    parameter int unsigned     PC_W        = 32,
    parameter int unsigned     DATA_W      = 32,
    parameter int unsigned     TRACE_DEPTH = 16,
    parameter int unsigned     STALL_LIMIT = 8,
    parameter int unsigned     TIMEOUT     = 2000,
    parameter logic [PC_W-1:0] END_PC      = '0,
    localparam int unsigned    IDX_W       = $clog2(TRACE_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_valid,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] check_val,
    input  logic [DATA_W-1:0] expect_val,
    input  logic [IDX_W-1:0]  trace_rd_idx,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timed_out,
    output logic [31:0]       cycle_count,
    output logic [31:0]       instr_count,
    output logic [IDX_W:0]    trace_count,
    output logic [PC_W-1:0]   trace_rd_pc,
    output logic [DATA_W-1:0] trace_rd_instr
);

`ifdef CPU_RUN_MONITOR_INSTR_TRACE_EN
    localparam int unsigned ENTRY_W = PC_W + DATA_W;
`else
    localparam int unsigned ENTRY_W = PC_W;
`endif

    localparam logic [31:0]    TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0]    STALL_LAST   = 32'(STALL_LIMIT - 1);
    localparam logic [IDX_W:0] TRACE_FULL   = (IDX_W + 1)'(TRACE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        cycle_count_q, cycle_count_d;
    logic [31:0]        instr_count_q, instr_count_d;
    logic [31:0]        stall_q, stall_d;
    logic [PC_W-1:0]    prev_pc_q, prev_pc_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]     trace_count_q, trace_count_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timed_out_q, timed_out_d;

    logic               accept_s;
    logic               halt_s;
    logic               timeout_s;
    logic [31:0]        stall_next_s;
    logic [ENTRY_W-1:0] ring_wdata_s;
    logic [IDX_W-1:0]   rd_addr_s;
    logic [ENTRY_W-1:0] rd_entry_s;
    logic               rd_visible_s;

    logic [ENTRY_W-1:0] ring_q [TRACE_DEPTH];

`ifdef CPU_RUN_MONITOR_INSTR_TRACE_EN
    assign ring_wdata_s = {pc, instr};
`else
    logic unused_instr_s;
    assign ring_wdata_s   = pc;
    assign unused_instr_s = ^instr;
`endif

    // Next-state logic: FSM transitions, counters and trace bookkeeping.
    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        stall_d       = stall_q;
        prev_pc_d     = prev_pc_q;
        wr_ptr_d      = wr_ptr_q;
        trace_count_d = trace_count_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timed_out_d   = timed_out_q;
        accept_s      = 1'b0;
        halt_s        = 1'b0;
        timeout_s     = 1'b0;
        stall_next_s  = stall_q;

        case (state_q)
            ST_IDLE: begin
                // The opening strobe is a real instruction: count it and
                // trace it. END_PC and stall detection only apply from RUN on.
                if (pc_valid) begin
                    accept_s = 1'b1;
                    stall_d  = 32'd0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                if (pc_valid) begin
                    accept_s = 1'b1;
                    // Counts repeats of the previous accepted PC. Cycles with
                    // no strobe leave the count unchanged.
                    if (pc == prev_pc_q) begin
                        stall_next_s = stall_q + 32'd1;
                    end else begin
                        stall_next_s = 32'd0;
                    end
                    stall_d = stall_next_s;
                    halt_s  = (pc == END_PC) || (stall_next_s == STALL_LAST);
                end else begin
                    halt_s  = 1'b0;
                end
                timeout_s = (cycle_count_q == TIMEOUT_LAST);
                // When halt and timeout land together, the halt wins.
                if (halt_s) begin
                    state_d = ST_CHECK;
                end else if (timeout_s) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    fail_d      = 1'b1;
                    timed_out_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CHECK: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                if (check_val == expect_val) begin
                    pass_d = 1'b1;
                end else begin
                    fail_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            instr_count_d = sat_inc(instr_count_q);
            prev_pc_d     = pc;
            wr_ptr_d      = wr_ptr_q + IDX_W'(1);
            if (trace_count_q != TRACE_FULL) begin
                trace_count_d = trace_count_q + (IDX_W + 1)'(1);
            end else begin
                trace_count_d = trace_count_q;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Control and status registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cycle_count_q <= 32'd0;
            instr_count_q <= 32'd0;
            stall_q       <= 32'd0;
            prev_pc_q     <= '0;
            wr_ptr_q      <= '0;
            trace_count_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
            stall_q       <= stall_d;
            prev_pc_q     <= prev_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            trace_count_q <= trace_count_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timed_out_q   <= timed_out_d;
        end
    end

    // Trace ring storage. It is not cleared on reset because trace_count
    // controls which entries are visible.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            ring_q[wr_ptr_q] <= ring_wdata_s;
        end
    end

    // Combinational trace read. Index 0 is the entry just before the write
    // pointer. Entries that are not valid read as 0.
    always_comb begin
        rd_addr_s      = wr_ptr_q - IDX_W'(1) - trace_rd_idx;
        rd_entry_s     = ring_q[rd_addr_s];
        rd_visible_s   = ({1'b0, trace_rd_idx} < trace_count_q);
        trace_rd_pc    = '0;
        trace_rd_instr = '0;
        if (rd_visible_s) begin
`ifdef CPU_RUN_MONITOR_INSTR_TRACE_EN
            trace_rd_pc    = rd_entry_s[ENTRY_W-1 -: PC_W];
            trace_rd_instr = rd_entry_s[DATA_W-1:0];
`else
            trace_rd_pc    = rd_entry_s[PC_W-1:0];
            trace_rd_instr = '0;
`endif
        end else begin
            trace_rd_pc    = '0;
            trace_rd_instr = '0;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
    assign trace_count = trace_count_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_monitor
//
// Scoreboard bench for cpu_run_monitor.
//   - The driver sends one program (a list of per-cycle strobes) per run.
//   - A reference model works from the list of accepted PCs and the RUN cycle
//     number to decide when the run ends, and why.
//   - When the model says the run is over, the expected result is pushed into
//     a queue.
//   - A monitor process pops that entry when done rises and compares the
//     verdict, the counters and the full trace against it.
// -----------------------------------------------------------------------------
module tb_cpu_run_monitor;
    localparam int          PC_W   = 32;
    localparam int          DATA_W = 32;
    localparam int          TD     = 4;
    localparam int          SL     = 8;
    localparam int          TO     = 50;
    localparam logic [31:0] ENDPC  = 32'h20;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic        pc_valid     = 1'b0;
    logic [31:0] pc           = 32'd0;
    logic [31:0] instr        = 32'd0;
    logic [31:0] check_val    = 32'd0;
    logic [31:0] expect_val   = 32'd0;
    logic [1:0]  trace_rd_idx = 2'd0;
    logic        done, pass, fail, timed_out;
    logic [31:0] cycle_count, instr_count;
    logic [2:0]  trace_count;
    logic [31:0] trace_rd_pc, trace_rd_instr;

    cpu_run_monitor #(
        .PC_W(PC_W), .DATA_W(DATA_W), .TRACE_DEPTH(TD), .STALL_LIMIT(SL),
        .TIMEOUT(TO), .END_PC(ENDPC)
    ) dut (
        .clk(clk), .reset(reset), .pc_valid(pc_valid), .pc(pc), .instr(instr),
        .check_val(check_val), .expect_val(expect_val), .trace_rd_idx(trace_rd_idx),
        .done(done), .pass(pass), .fail(fail), .timed_out(timed_out),
        .cycle_count(cycle_count), .instr_count(instr_count), .trace_count(trace_count),
        .trace_rd_pc(trace_rd_pc), .trace_rd_instr(trace_rd_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
    } step_t;

    typedef struct packed {
        logic            pass;
        logic            fail;
        logic            tout;
        logic [31:0]     cyc;
        logic [31:0]     icnt;
        logic [31:0]     tcnt;
        logic [3:0][31:0] tpc;
        logic [3:0][31:0] tins;
    } exp_t;

    exp_t        exp_q[$];
    step_t       prog[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_ins[$];
    int          m_phase;   // 0 idle, 1 running, 2 finished
    int unsigned m_cyc;
    logic        m_tout;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] p);
        step_t s;
        s.v   = v;
        s.pc  = p;
        s.ins = $urandom;
        prog.push_back(s);
    endtask

    // Number of trailing accepted PCs equal to the most recent one.
    function automatic int run_len();
        int n;
        n = 0;
        for (int i = acc_pc.size() - 1; i >= 0; i--) begin
            if (acc_pc[i] == acc_pc[acc_pc.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_step(input step_t s);
        bit halt;
        halt = 1'b0;
        if (m_phase == 0) begin
            if (s.v) begin
                acc_pc.push_back(s.pc);
                acc_ins.push_back(s.ins);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_cyc++;
            if (s.v) begin
                acc_pc.push_back(s.pc);
                acc_ins.push_back(s.ins);
                halt = (s.pc == ENDPC) || (run_len() >= SL);
            end
            if (halt) begin
                m_phase = 2;
                m_tout  = 1'b0;
            end else if (m_cyc == TO) begin
                m_phase = 2;
                m_tout  = 1'b1;
            end
        end
    endtask

    function automatic exp_t make_exp(input logic [31:0] cv, input logic [31:0] ev);
        exp_t e;
        int   n;
        n      = acc_pc.size();
        e      = '0;
        e.tout = m_tout;
        e.pass = !m_tout && (cv == ev);
        e.fail = !e.pass;
        e.cyc  = m_cyc;
        e.icnt = n;
        e.tcnt = (n < TD) ? n : TD;
        for (int k = 0; k < TD; k++) begin
            if (k < e.tcnt) begin
                e.tpc[k] = acc_pc[n - 1 - k];
`ifdef CPU_RUN_MONITOR_INSTR_TRACE_EN
                e.tins[k] = acc_ins[n - 1 - k];
`else
                e.tins[k] = 32'd0;
`endif
            end
        end
        return e;
    endfunction

    // Resets the DUT, plays prog, and checks that the results stay frozen
    // after done.
    task automatic run_case(input logic [31:0] cv, input logic [31:0] ev);
        step_t s;
        exp_t  e;
        int    w;
        reset = 1'b0;
        pc_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_val  = cv;
        expect_val = ev;
        acc_pc.delete();
        acc_ins.delete();
        m_phase = 0;
        m_cyc   = 0;
        m_tout  = 1'b0;
        e       = '0;
        w       = 0;
        while (m_phase != 2 && w < 300) begin
            if (prog.size() > 0) s = prog.pop_front();
            else s = '0;
            pc_valid = s.v;
            pc       = s.pc;
            instr    = s.ins;
            model_step(s);
            if (m_phase == 2) begin
                e = make_exp(cv, ev);
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            w++;
        end
        prog.delete();
        // After the end, keep sending strobes. The DUT must ignore them.
        w = 0;
        while (exp_q.size() != 0 && w < 10) begin
            pc_valid = 1'b1;
            pc       = $urandom;
            instr    = $urandom;
            @(posedge clk); #1;
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait: done not seen within 10 cycles, %0d pending", exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin
            pc_valid = 1'b1;
            pc       = $urandom;
            @(posedge clk); #1;
        end
        pc_valid = 1'b0;
        chk("frozen_done", {31'd0, done}, 32'd1);
        chk("frozen_instr_count", instr_count, e.icnt);
        chk("frozen_cycle_count", cycle_count, e.cyc);
    endtask

    // Monitor: compare each finished run against the scoreboard head.
    initial begin
        exp_t e;
        logic dprev;
        dprev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                dprev = 1'b0;
            end else begin
                if (done && !dprev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done=1 with empty scoreboard");
                    end else begin
                        e = exp_q[0];
                        chk("pass", {31'd0, pass}, {31'd0, e.pass});
                        chk("fail", {31'd0, fail}, {31'd0, e.fail});
                        chk("timed_out", {31'd0, timed_out}, {31'd0, e.tout});
                        chk("cycle_count", cycle_count, e.cyc);
                        chk("instr_count", instr_count, e.icnt);
                        chk("trace_count", {29'd0, trace_count}, e.tcnt);
                        for (int k = 0; k < TD; k++) begin
                            trace_rd_idx = 2'(k);
                            #1;
                            chk($sformatf("trace_pc[%0d]", k), trace_rd_pc, e.tpc[k]);
                            chk($sformatf("trace_instr[%0d]", k), trace_rd_instr, e.tins[k]);
                        end
                        trace_rd_idx = 2'd0;
                        void'(exp_q.pop_front());
                    end
                end
                dprev = done;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lp;
        int          dens, rep;
        #1;

        // Normal end at END_PC, matching check.
        add(1'b1, 32'h0); add(1'b1, 32'h4); add(1'b1, 32'h8); add(1'b1, 32'h20);
        run_case(32'h37, 32'h37);

        // Same PC committed STALL_LIMIT times, mismatching check.
        add(1'b1, 32'h0);
        for (int i = 0; i < SL; i++) add(1'b1, 32'hC);
        run_case(32'd5, 32'd6);

        // Strobe every 3 cycles, no halt: timeout.
        for (int i = 0; i < 60; i++) add((i % 3) == 0, 32'h100 + 32'(4 * (i / 3)));
        run_case(32'd1, 32'd1);

        // Ring wrap: last four kept, newest first.
        for (int i = 0; i < 6; i++) add(1'b1, 32'(4 * i));
        add(1'b1, ENDPC);
        run_case(32'd9, 32'd9);

        // Single strobe then timeout: only one trace entry is visible.
        add(1'b1, 32'h44);
        run_case(32'd3, 32'd3);

        // Halt and timeout in the same cycle: check decides, no timeout.
        add(1'b1, 32'h40);
        for (int i = 1; i < TO; i++) add(1'b0, 32'h0);
        add(1'b1, ENDPC);
        run_case(32'h11, 32'h11);
        add(1'b1, 32'h40);
        for (int i = 1; i < TO; i++) add(i % 5 == 0, 32'h200 + 32'(4 * i));
        add(1'b1, ENDPC);
        run_case(32'h11, 32'h12);

        // Reset mid-RUN after 10 strobes: clears at once, before any edge.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_valid = 1'b1;
            pc       = 32'h100 + 32'(4 * i);
            @(posedge clk); #1;
        end
        pc_valid = 1'b0;
        chk("pre_reset_instr_count", instr_count, 32'd10);
        chk("pre_reset_cycle_count", cycle_count, 32'd9);
        chk("pre_reset_trace_pc0", trace_rd_pc, 32'h124);
        reset = 1'b0;
        #1;
        chk("async_reset_done", {31'd0, done}, 32'd0);
        chk("async_reset_instr_count", instr_count, 32'd0);
        chk("async_reset_cycle_count", cycle_count, 32'd0);
        chk("async_reset_trace_count", {29'd0, trace_count}, 32'd0);
        chk("async_reset_trace_pc0", trace_rd_pc, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_cycle_count", cycle_count, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);

        // Random programs against the reference model.
        for (int t = 0; t < 25; t++) begin
            dens = $urandom_range(20, 95);
            rep  = $urandom_range(30, 95);
            lp   = 32'(4 * $urandom_range(0, 15));
            add(1'b1, lp);
            for (int i = 1; i < 60; i++) begin
                if ($urandom_range(0, 99) < dens) begin
                    if ($urandom_range(0, 99) < rep) begin
                        // repeat the last PC
                    end else if ($urandom_range(0, 99) < 5) begin
                        lp = ENDPC;
                    end else begin
                        lp = 32'(4 * $urandom_range(0, 15));
                    end
                    add(1'b1, lp);
                end else begin
                    add(1'b0, 32'(4 * $urandom_range(0, 15)));
                end
            end
            lp = $urandom;
            run_case(lp, ($urandom_range(0, 1) == 1) ? lp : (lp ^ 32'h1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
